fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 35 +++
 rtl/fetch_ctrl_npc.sv | 29 ++
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU constants and types for the instruction fetch sequencer.
// Holds the reset PC, the exception vector, next-PC select codes and fetch state encoding.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned JUMP_W   = 26;
    localparam int unsigned REGION_W = 4;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_REG    = 2'b11
    } npc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_VALID,
        ST_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_pkt_t;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Next-PC unit: sequential, branch, jump-region and register targets.
// Pure combinational; all arithmetic wraps modulo 2^32.
module fetch_ctrl_npc
    import fetch_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  npc_op_t           npc_op,
    input  logic [JUMP_W-1:0] ins26,
    input  logic [XLEN-1:0]   ext32,
    input  logic [XLEN-1:0]   rfrs32,
    output logic [XLEN-1:0]   npc_c
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        npc_c = pc_plus4;
        case (npc_op)
            NPC_SEQ:    npc_c = pc_plus4;
            NPC_BRANCH: npc_c = pc_plus4 + (ext32 << 2);
            NPC_JUMP:   npc_c = {pc[XLEN-1 -: REGION_W], ins26, 2'b00};
            NPC_REG:    npc_c = rfrs32;
            default:    npc_c = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues word requests, holds the fetched instruction
// until consumed, and redirects to the exception vector on exc_req or a bad target.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [1:0]        npc_op,
    input  logic [JUMP_W-1:0] d_ins26,
    input  logic [XLEN-1:0]   d_ext32,
    input  logic [XLEN-1:0]   d_rfrs32,
    input  logic              exc_req,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              ins_valid,
    output logic [XLEN-1:0]   ins_out,
    output logic [XLEN-1:0]   pc_out,
    output logic              addr_err
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] npc_c;
    logic [XLEN-1:0] imem_addr_d;
    fetch_pkt_t      held, held_d;
    logic            ins_valid_d;
    logic            imem_req_d;
    logic            addr_err_d;

    fetch_ctrl_npc u_npc (
        .pc     (pc),
        .npc_op (npc_op_t'(npc_op)),
        .ins26  (d_ins26),
        .ext32  (d_ext32),
        .rfrs32 (d_rfrs32),
        .npc_c  (npc_c)
    );

    assign ins_out = held.ins;
    assign pc_out  = held.pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            held      <= '0;
            ins_valid <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            held      <= held_d;
            ins_valid <= ins_valid_d;
            imem_req  <= imem_req_d;
            imem_addr <= imem_addr_d;
            addr_err  <= addr_err_d;
        end
    end

    // exc_req outranks stall and npc_op everywhere; an open handshake is never withdrawn
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        held_d      = held;
        ins_valid_d = ins_valid;
        addr_err_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                ins_valid_d = 1'b0;
                if (exc_req) begin
                    pc_d = EXC_VECTOR;
                end
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (exc_req) begin
                    pc_d        = EXC_VECTOR;
                    ins_valid_d = 1'b0;
                    state_d     = imem_ack ? ST_REQ : ST_DROP;
                end else if (imem_ack) begin
                    held_d      = '{pc: pc, ins: imem_rdata};
                    ins_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end
            end
            ST_VALID: begin
                if (exc_req) begin
                    pc_d        = EXC_VECTOR;
                    ins_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end else if (!stall) begin
                    ins_valid_d = 1'b0;
                    state_d     = ST_REQ;
                    if (misaligned(npc_c)) begin
                        pc_d       = EXC_VECTOR;
                        addr_err_d = 1'b1;
                    end else begin
                        pc_d = npc_c;
                    end
                end
            end
            ST_DROP: begin
                ins_valid_d = 1'b0;
                if (exc_req) begin
                    pc_d = EXC_VECTOR;
                end
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                ins_valid_d = 1'b0;
            end
        endcase

        imem_req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
        // a dropped request keeps its original address until acknowledged
        imem_addr_d = (state_d == ST_REQ) ? pc_d : imem_addr;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected requests, instructions and
// address errors; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  npc_op;
    logic [25:0] d_ins26;
    logic [31:0] d_ext32;
    logic [31:0] d_rfrs32;
    logic        exc_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_ins_q[$];
    bit          exp_err_q[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .npc_op     (npc_op),
        .d_ins26    (d_ins26),
        .d_ext32    (d_ext32),
        .d_rfrs32   (d_rfrs32),
        .exc_req    (exc_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins_valid  (ins_valid),
        .ins_out    (ins_out),
        .pc_out     (pc_out),
        .addr_err   (addr_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a new request is req rising, or req still high after an accepted ack
    logic        m_prev_req   = 1'b0;
    logic        m_prev_valid = 1'b0;
    logic        m_new_req;
    logic [31:0] m_last_addr  = '0;
    logic [63:0] m_last_ins   = '0;

    always @(negedge clk) begin
        m_new_req = imem_req && (!m_prev_req || imem_ack);
        if (m_new_req) begin
            if (exp_addr_q.size() == 0)
                chk("req_expected", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("req_addr", 64'(imem_addr), 64'(exp_addr_q.pop_front()));
            m_last_addr = imem_addr;
        end else if (imem_req) begin
            chk("req_addr_hold", 64'(imem_addr), 64'(m_last_addr));
        end

        if (ins_valid && !m_prev_valid) begin
            if (exp_ins_q.size() == 0)
                chk("ins_expected", {pc_out, ins_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("ins_pc_data", {pc_out, ins_out}, exp_ins_q.pop_front());
            m_last_ins = {pc_out, ins_out};
        end else if (ins_valid) begin
            chk("ins_hold", {pc_out, ins_out}, m_last_ins);
        end

        if (addr_err) begin
            chk("addr_err_expected", 64'(exp_err_q.size()), 64'(exp_err_q.size() == 0 ? 1 : exp_err_q.size()));
            if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
        end

        m_prev_req   = imem_req;
        m_prev_valid = ins_valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!imem_req && k < 20) begin
            step();
            k++;
        end
        chk("req_seen", 64'(imem_req), 64'd1);
    endtask

    task automatic serve(input int delay, input logic [31:0] data, input logic [31:0] exp_pc);
        wait_req();
        repeat (delay) step();
        exp_ins_q.push_back({exp_pc, data});
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic consume(input logic [1:0] op, input logic [25:0] i26,
                           input logic [31:0] ext, input logic [31:0] rfrs);
        stall    = 1'b0;
        npc_op   = op;
        d_ins26  = i26;
        d_ext32  = ext;
        d_rfrs32 = rfrs;
        step();
        stall    = 1'b1;
        npc_op   = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        stall      = 1'b1;
        npc_op     = 2'b00;
        d_ins26    = '0;
        d_ext32    = '0;
        d_rfrs32   = '0;
        exc_req    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        repeat (3) step();

        chk("rst_imem_req",  64'(imem_req),  64'd0);
        chk("rst_ins_valid", 64'(ins_valid), 64'd0);
        chk("rst_ins_out",   64'(ins_out),   64'd0);
        chk("rst_pc_out",    64'(pc_out),    64'd0);
        chk("rst_addr_err",  64'(addr_err),  64'd0);

        // first fetch from the reset PC, ack after 2 cycles
        exp_addr_q.push_back(32'h0000_3000);
        rst = 1'b1;
        serve(2, 32'h2408_0001, 32'h0000_3000);

        repeat (3) begin
            step();
            chk("stall_no_req", 64'(imem_req),  64'd0);
            chk("stall_valid",  64'(ins_valid), 64'd1);
        end

        exp_addr_q.push_back(32'h0000_3004);
        consume(2'b00, '0, '0, '0);
        serve(0, 32'h8C01_0004, 32'h0000_3004);

        exp_addr_q.push_back(32'h0000_3008);
        consume(2'b00, '0, '0, '0);
        serve(0, 32'h1000_FFFF, 32'h0000_3008);

        // branch back by one word lands on the same PC
        exp_addr_q.push_back(32'h0000_3008);
        consume(2'b01, '0, 32'hFFFF_FFFF, '0);
        serve(1, 32'h0800_0C40, 32'h0000_3008);

        exp_addr_q.push_back(32'h0000_3100);
        consume(2'b10, 26'h000_0C40, '0, '0);
        serve(0, 32'h0000_0008, 32'h0000_3100);

        // misaligned register target redirects to the vector
        exp_err_q.push_back(1'b1);
        exp_addr_q.push_back(32'h0000_4180);
        consume(2'b11, '0, '0, 32'h0000_3002);
        serve(0, 32'h03E0_0008, 32'h0000_4180);

        exp_addr_q.push_back(32'hFFFF_FFFC);
        consume(2'b11, '0, '0, 32'hFFFF_FFFC);
        serve(0, 32'h0000_0000, 32'hFFFF_FFFC);

        exp_addr_q.push_back(32'h0000_0000);
        consume(2'b00, '0, '0, '0);

        // exception while request to 0 outstanding; exc again while dropping
        exp_addr_q.push_back(32'h0000_4180);
        exc_req = 1'b1;
        step();
        step();
        exc_req = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        serve(0, 32'h1111_1111, 32'h0000_4180);

        // exception while holding a valid instruction
        exp_addr_q.push_back(32'h0000_4180);
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        chk("exc_valid_drop", 64'(ins_valid), 64'd0);

        // exception coinciding with ack discards the response
        exp_addr_q.push_back(32'h0000_4180);
        exc_req    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        exc_req    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        serve(1, 32'h2222_2222, 32'h0000_4180);

        // reset mid-request, late ack during reset, exc on release from IDLE
        exp_addr_q.push_back(32'h0000_4184);
        consume(2'b00, '0, '0, '0);
        rst = 1'b0;
        step();
        chk("rst_mid_req",   64'(imem_req),  64'd0);
        chk("rst_mid_valid", 64'(ins_valid), 64'd0);
        imem_ack = 1'b1;
        step();
        exp_addr_q.push_back(32'h0000_4180);
        rst     = 1'b1;
        exc_req = 1'b1;
        step();
        exc_req  = 1'b0;
        imem_ack = 1'b0;
        chk("idle_exc_no_valid", 64'(ins_valid), 64'd0);
        serve(0, 32'h3333_3333, 32'h0000_4180);

        repeat (4) step();
        chk("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
        chk("ins_q_empty",  64'(exp_ins_q.size()),  64'd0);
        chk("err_q_empty",  64'(exp_err_q.size()),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
